// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshake bundle for the bit-serial adder.
interface serial_adder_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out
    );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic hs1;
    logic hc1;
    logic hc2;

    assign hs1 = x ^ y;
    assign hc1 = x & y;
    assign s   = hs1 ^ ci;
    assign hc2 = hs1 & ci;
    assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell swept LSB-first with a carry flop.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// SHIFT | one bit added per edge, bit_cnt counts processed bits
// DONE  | result presented with out_valid=1 until out_ready
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [WIDTH-1:0] sum_sh_q,  sum_sh_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             carry_q,   carry_d;
    logic             c_out_q,   c_out_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            c_out_q   <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            c_out_q   <= c_out_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d    = bus.a;
                    b_sh_d    = bus.b;
                    carry_d   = bus.c_in;
                    sum_sh_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                sum_sh_d  = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d   = fa_co;
                bit_cnt_d = bit_cnt_q + CW'(1);
                // Result is latched separately so it survives the next operand load.
                if (bit_cnt_q == LAST) begin
                    sum_d   = sum_sh_d;
                    c_out_d = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH 8, 1 and 13.
module tb_serial_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  bus8  ();
    serial_adder_if #(.WIDTH(1))  bus1  ();
    serial_adder_if #(.WIDTH(13)) bus13 ();

    serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_adder #(.WIDTH(13)) u_dut13 (.clk(clk), .rst_n(rst_n), .bus(bus13));

    int          sel = 0;
    logic        iv_t = 1'b0;
    logic        or_t = 1'b0;
    logic        c_t  = 1'b0;
    logic [12:0] a_t  = '0;
    logic [12:0] b_t  = '0;

    assign bus8.in_valid   = iv_t && (sel == 0);
    assign bus8.out_ready  = or_t && (sel == 0);
    assign bus8.a          = a_t[7:0];
    assign bus8.b          = b_t[7:0];
    assign bus8.c_in       = c_t;
    assign bus1.in_valid   = iv_t && (sel == 1);
    assign bus1.out_ready  = or_t && (sel == 1);
    assign bus1.a          = a_t[0:0];
    assign bus1.b          = b_t[0:0];
    assign bus1.c_in       = c_t;
    assign bus13.in_valid  = iv_t && (sel == 2);
    assign bus13.out_ready = or_t && (sel == 2);
    assign bus13.a         = a_t;
    assign bus13.b         = b_t;
    assign bus13.c_in      = c_t;

    logic        rdy_o;
    logic        ov_o;
    logic        co_o;
    logic [12:0] sum_o;

    always_comb begin
        rdy_o = bus8.in_ready;
        ov_o  = bus8.out_valid;
        co_o  = bus8.c_out;
        sum_o = 13'(bus8.sum);
        case (sel)
            1: begin
                rdy_o = bus1.in_ready;
                ov_o  = bus1.out_valid;
                co_o  = bus1.c_out;
                sum_o = 13'(bus1.sum);
            end
            2: begin
                rdy_o = bus13.in_ready;
                ov_o  = bus13.out_valid;
                co_o  = bus13.c_out;
                sum_o = bus13.sum;
            end
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 0) ? 8 : ((s == 1) ? 1 : 13);
    endfunction

    // One full transaction; called at a negedge, returns at a negedge with the DUT back in IDLE.
    task automatic xfer(input int s, input logic [12:0] a, input logic [12:0] b, input logic c,
                        input int hold, input bit noisy,
                        output logic [12:0] so, output logic co);
        int n;
        int lat;
        sel  = s;
        a_t  = a;
        b_t  = b;
        c_t  = c;
        iv_t = 1'b1;
        or_t = 1'b0;
        n = 0;
        while (rdy_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(rdy_o), 32'd1);
        @(negedge clk);
        iv_t = 1'b0;
        lat  = 0;
        while (ov_o !== 1'b1 && lat < 40) begin
            if (noisy) begin
                iv_t = 1'($urandom_range(0, 1));
                a_t  = 13'($urandom);
                b_t  = 13'($urandom);
                c_t  = 1'($urandom_range(0, 1));
                or_t = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            lat++;
        end
        check("valid_rise", 32'(ov_o), 32'd1);
        check("latency", 32'(lat), 32'(width_of(s)));
        or_t = 1'b0;
        so   = sum_o;
        co   = co_o;
        for (int i = 0; i < hold; i++) begin
            iv_t = 1'b1;
            a_t  = 13'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(ov_o), 32'd1);
            check("hold_sum", 32'(sum_o), 32'(so));
            check("hold_cout", 32'(co_o), 32'(co));
        end
        iv_t = 1'b0;
        or_t = 1'b1;
        @(negedge clk);
        or_t = 1'b0;
        check("valid_drop", 32'(ov_o), 32'd0);
        check("ready_after", 32'(rdy_o), 32'd1);
        check("sum_kept", 32'(sum_o), 32'(so));
    endtask

    logic [1:0]  fa_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [12:0] so;
    logic        co;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(rdy_o), 32'd1);
        check("rst_valid", 32'(ov_o), 32'd0);
        check("rst_sum", 32'(sum_o), 32'd0);
        check("rst_cout", 32'(co_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(0, 13'h5A, 13'h33, 1'b0, 0, 1'b0, so, co);
        check("t1_sum", 32'(so), 32'h8D);
        check("t1_cout", 32'(co), 32'd0);
        xfer(0, 13'hFF, 13'h01, 1'b1, 0, 1'b0, so, co);
        check("ovf1_sum", 32'(so), 32'h01);
        check("ovf1_cout", 32'(co), 32'd1);
        xfer(0, 13'hFF, 13'h00, 1'b1, 0, 1'b0, so, co);
        check("ovf2_sum", 32'(so), 32'h00);
        check("ovf2_cout", 32'(co), 32'd1);
        xfer(0, 13'h10, 13'h20, 1'b0, 5, 1'b1, so, co);
        check("bp_sum", 32'(so), 32'h30);
        check("bp_cout", 32'(co), 32'd0);

        // abort a transaction three shift edges in
        sel  = 0;
        a_t  = 13'hAA;
        b_t  = 13'h55;
        c_t  = 1'b0;
        iv_t = 1'b1;
        @(negedge clk);
        iv_t = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(rdy_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(ov_o), 32'd0);
        check("abort_sum", 32'(sum_o), 32'd0);
        check("abort_cout", 32'(co_o), 32'd0);
        check("abort_ready", 32'(rdy_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 13'h01, 13'h01, 1'b0, 0, 1'b0, so, co);
        check("post_rst_sum", 32'(so), 32'h02);
        check("post_rst_cout", 32'(co), 32'd0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            xfer(1, 13'(v[2]), 13'(v[1]), v[0], 0, 1'b0, so, co);
            check("w1_sum", 32'(so), 32'(fa_exp[i][0]));
            check("w1_cout", 32'(co), 32'(fa_exp[i][1]));
        end

        for (int s = 0; s <= 2; s += 2) begin
            int          w;
            logic [12:0] mask;
            logic [12:0] ra;
            logic [12:0] rb;
            logic        rc;
            logic [13:0] full;
            w    = width_of(s);
            mask = 13'((1 << w) - 1);
            sel  = s;
            for (int t = 0; t < 500; t++) begin
                ra = 13'($urandom) & mask;
                rb = 13'($urandom) & mask;
                rc = 1'($urandom_range(0, 1));
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    check("idle_valid", 32'(ov_o), 32'd0);
                end
                xfer(s, ra, rb, rc, $urandom_range(0, 2), 1'b1, so, co);
                full = {1'b0, ra} + {1'b0, rb} + 14'(rc);
                check("rnd_sum", 32'(so), 32'(full[12:0] & mask));
                check("rnd_cout", 32'(co), 32'(full[w]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one full-adder cell plus a carry flip-flop.
- Accepts two WIDTH-bit operands and a carry-in via valid/ready handshake.
- Adds LSB-first, one bit per clock; presents the sum and carry-out via valid/ready handshake.
- Sits directly downstream of the combinational full-adder stage: it sequences that stage over time to trade area for latency.

Parameters:
- WIDTH, 8, operand/sum width in bits (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, c_in valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in
- out_valid  output  1  sum/c_out valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + c_in, low WIDTH bits
- c_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset: rst_n low asynchronously clears all state.
  - state=IDLE; a_sh, b_sh, sum_sh = 0; carry=0; bit_cnt=0.
  - Outputs: out_valid=0, sum=0, c_out=0, in_ready=1 (in_ready = state==IDLE, combinational).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at an edge: load a_sh=a, b_sh=b, carry=c_in, bit_cnt=0, sum_sh=0, then go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0, out_valid=0; a, b, c_in and in_valid are ignored.
  - Each edge: fa_cell(a_sh[0], b_sh[0], carry) -> (s, co).
  - sum_sh = {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right with zero fill; carry=co; bit_cnt++.
  - On the edge where bit_cnt==WIDTH-1: perform the final shift, then go to DONE.
- DONE:
  - out_valid=1, sum=sum_sh, c_out=carry; both held stable until handshake.
  - out_ready=1 at an edge: go to IDLE; sum and c_out retain their values, only out_valid drops.
  - in_valid in DONE is not accepted (in_ready=0); the next accept happens no earlier than the first IDLE cycle.
- Latency:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - Throughput: one result per WIDTH+2 cycles at best (accept, WIDTH shifts, handshake).
- Arithmetic: {c_out, sum} == a + b + c_in, exact over WIDTH+1 bits; wrap-around shows only as c_out=1.
- bit_cnt width: max(1, $clog2(WIDTH)). WIDTH=1 goes straight from one SHIFT edge to DONE.
- sum/c_out outside DONE: hold last completed result (0 after reset). Not meaningful unless out_valid=1.
- Reset mid-SHIFT or mid-DONE:
  - Immediate abort; partial result discarded; out_valid=0 without handshake.
  - First accept is possible on the first edge after rst_n rises.
- out_ready while out_valid=0: ignored.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - a function computing counter width from WIDTH.
- One sub-module, fa_cell: purely combinational 1-bit full adder (two half-adder cells + OR), inputs x, y, ci, outputs s, co.
- fa_cell is instantiated once in serial_adder; the FSM, shift registers, carry flop and counter stay in the top.

Test Plan:
- WIDTH=8: a=0x5A, b=0x33, c_in=0, out_ready=1 -> out_valid rises 8 edges after accept; sum=0x8D, c_out=0; in_ready=1 the cycle after handshake.
- WIDTH=8: a=0xFF, b=0x01, c_in=1 -> sum=0x01, c_out=1. Then a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1.
- Backpressure: a=0x10, b=0x20, c_in=0, out_ready held 0 for 5 cycles in DONE -> out_valid=1 and sum=0x30 stable all 5 cycles; in_valid pulses during SHIFT/DONE are not accepted; out_ready=1 -> IDLE next edge.
- Reset mid-operation: accept a=0xAA, b=0x55; pull rst_n low after 3 SHIFT edges -> immediately out_valid=0, sum=0x00, c_out=0, in_ready=1. Release, then send a=0x01, b=0x01, c_in=0 -> sum=0x02, c_out=0.
- WIDTH=1 exhaustive: all 8 {a,b,c_in} combinations -> {c_out,sum} matches the full-adder truth table (e.g. 1,1,1 -> c_out=1, sum=1); out_valid 1 edge after accept.
- Random regression, WIDTH=8 and WIDTH=13: 500 transactions with random in_valid/out_ready gaps -> every result equals a+b+c_in; no lost or duplicated transactions.
